// File: rtl/fp_mul_booth_seq.sv
`default_nettype none
// ============================================================================
// Module   : fp_mul_booth_seq
// Brief    : Sequential IEEE-754 multiplier, radix-4 Booth (one digit per clock),
//            round-to-nearest-even, flush-to-zero. Optional flags port: FP_MUL_FLAGS_EN.
// Revision : 1.0
// ============================================================================
module fp_mul_booth_seq #(
    parameter int EW = 8,
    parameter int MW = 23
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [EW+MW:0]  a,
    input  logic [EW+MW:0]  b,
    output logic            busy,
    output logic            done,
    output logic [EW+MW:0]  result
`ifdef FP_MUL_FLAGS_EN
    ,
    output logic [4:0]      flags
`endif
);
    localparam int W    = 1 + EW + MW;
    localparam int SW   = MW + 1;
    localparam int ITER = (MW + 3) / 2;
    localparam int PW   = 2 * SW + 2;
    localparam int MPW  = 2 * ITER + 1;
    localparam int XW   = EW + 2;
    localparam int CW   = $clog2(ITER);
    localparam logic signed [XW-1:0] BIAS = XW'((1 << (EW - 1)) - 1);
    localparam logic signed [XW-1:0] EMAX = XW'((1 << EW) - 1);

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_NORM, S_RND, S_WB} state_t;
    typedef enum logic [2:0] {K_NORM, K_NAN, K_INF, K_ZERO, K_OVF, K_UNF} kind_t;

    state_t                 state;
    kind_t                  spec_r, spec_in, kind;
    logic [CW-1:0]          cnt;
    logic                   sign_r;
    logic signed [XW-1:0]   exp_r;
    logic [PW-1:0]          acc, mcand, pp;
    logic [MPW-1:0]         mplier;
    logic [MW-1:0]          mant_r;
    logic [W-1:0]           res_n;

    logic [EW-1:0] ea, eb;
    logic [MW-1:0] ma, mb;
    logic          a_max, b_max, a_zero, b_zero, a_nan, b_nan;

    assign ea     = a[W-2:MW];
    assign eb     = b[W-2:MW];
    assign ma     = a[MW-1:0];
    assign mb     = b[MW-1:0];
    assign a_max  = &ea;
    assign b_max  = &eb;
    assign a_zero = ~|ea;
    assign b_zero = ~|eb;
    assign a_nan  = a_max & (|ma);
    assign b_nan  = b_max & (|mb);

    // Subnormal inputs count as zero, so inf x subnormal is also invalid.
    always_comb begin
        spec_in = K_NORM;
        if (a_nan || b_nan || (a_max && b_zero) || (b_max && a_zero))
            spec_in = K_NAN;
        else if (a_max || b_max)
            spec_in = K_INF;
        else if (a_zero || b_zero)
            spec_in = K_ZERO;
    end

    always_comb begin
        case (mplier[2:0])
            3'b001, 3'b010: pp = mcand;
            3'b011:         pp = mcand << 1;
            3'b100:         pp = -(mcand << 1);
            3'b101, 3'b110: pp = -mcand;
            default:        pp = '0;
        endcase
    end

    // After normalisation the hidden bit sits at 2*SW-2; fraction, guard, round, sticky follow.
    logic [MW-1:0] frac;
    logic          guard, rnd, sticky, inc;
    logic [MW:0]   frac_rnd;
    logic          unused_bits;

    assign frac        = acc[2*SW-3 -: MW];
    assign guard       = acc[SW-2];
    assign rnd         = acc[SW-3];
    assign sticky      = |acc[SW-4:0];
    assign inc         = guard & (rnd | sticky | frac[0]);
    assign frac_rnd    = {1'b0, frac} + {{MW{1'b0}}, inc};
    assign unused_bits = ^{acc[PW-1:2*SW], acc[2*SW-2]};

    always_comb begin
        kind = spec_r;
        if (spec_r == K_NORM) begin
            if (exp_r >= EMAX)
                kind = K_OVF;
            else if (exp_r[XW-1] || (exp_r == '0))
                kind = K_UNF;
        end
    end

    always_comb begin
        case (kind)
            K_NAN:        res_n = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};
            K_INF, K_OVF: res_n = {sign_r, {EW{1'b1}}, {MW{1'b0}}};
            K_ZERO, K_UNF: res_n = {sign_r, {(EW+MW){1'b0}}};
            default:      res_n = {sign_r, exp_r[EW-1:0], mant_r};
        endcase
    end

`ifdef FP_MUL_FLAGS_EN
    logic       inex_r;
    logic [4:0] flags_n;
    assign flags_n = {kind == K_NAN,
                      kind == K_OVF,
                      kind == K_UNF,
                      (kind == K_OVF) || (kind == K_UNF) || ((kind == K_NORM) && inex_r),
                      (kind == K_ZERO) || (kind == K_UNF)};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            spec_r <= K_NORM;
            cnt    <= '0;
            sign_r <= 1'b0;
            exp_r  <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            mant_r <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
`ifdef FP_MUL_FLAGS_EN
            inex_r <= 1'b0;
            flags  <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        sign_r <= a[W-1] ^ b[W-1];
                        spec_r <= spec_in;
                        exp_r  <= $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
                        acc    <= '0;
                        mcand  <= PW'({1'b1, ma});
                        mplier <= {{(MPW-SW-1){1'b0}}, 1'b1, mb, 1'b0};
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= S_MUL;
                    end
                end
                S_MUL: begin
                    acc    <= acc + pp;
                    mcand  <= mcand << 2;
                    mplier <= mplier >> 2;
                    cnt    <= cnt + CW'(1);
                    if (cnt == CW'(ITER - 1))
                        state <= S_NORM;
                end
                S_NORM: begin
                    if (acc[2*SW-1]) begin
                        acc   <= {1'b0, acc[PW-1:2], acc[1] | acc[0]};
                        exp_r <= exp_r + XW'(1);
                    end
                    state <= S_RND;
                end
                S_RND: begin
                    mant_r <= frac_rnd[MW-1:0];
                    if (frac_rnd[MW])
                        exp_r <= exp_r + XW'(1);
`ifdef FP_MUL_FLAGS_EN
                    inex_r <= guard | rnd | sticky;
`endif
                    state <= S_WB;
                end
                S_WB: begin
                    result <= res_n;
`ifdef FP_MUL_FLAGS_EN
                    flags  <= flags_n;
`endif
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire
